// File: rtl/alu_seq_display.sv
// alu_seq_display: clocked eight-op ALU with a start/busy/done handshake,
// multi-cycle variable shifts, and a time-multiplexed hex 7-segment display.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, sel, rs, rt request, opcode and operands (sampled when not shifting)
//   busy, done, rd    shift in progress, one-cycle completion pulse, result
//   seg, an           active-low segments (seg[6]=a..seg[0]=g), active-low digit enables
module alu_seq_display #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         sel,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   rd,
  output logic [6:0]         seg,
  output logic [WIDTH/4-1:0] an
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned SHW    = $clog2(WIDTH);
  localparam int unsigned DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // 1010... pattern over the upper WIDTH-1 result bits, MSB first
  function automatic logic [WIDTH-2:0] alt_pat();
    logic [WIDTH-2:0] p;
    p = '0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) p[int'(WIDTH) - 2 - i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [WIDTH-2:0] ALT = alt_pat();

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_sel, w_sel_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic [WIDTH-1:0]   r_work, w_work_nxt;
  logic [SHW-1:0]     r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_rd, w_rd_nxt;
  logic               r_done, w_done_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_accept;
  logic               w_is_shift;
  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_alu;

  logic [REFRESH_BITS-1:0] r_refresh;
  logic [DW-1:0]           r_digit;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;

  // Opcode decode of the incoming request: rotate uses rt as amount, asr uses rs
  assign w_is_shift = (sel[2:1] == 2'b10);
  assign w_amt      = sel[0] ? rs[SHW-1:0] : rt[SHW-1:0];

  // Result of the latched operation; shifts finish in the work register
  always_comb begin
    w_alu = r_work;
    case (r_sel)
      3'd0:    w_alu = r_a + r_b;
      3'd1:    w_alu = r_a + ~r_b + WIDTH'(1);
      3'd2:    w_alu = r_a & r_b;
      3'd3:    w_alu = r_a | r_b;
      3'd6:    w_alu = {{(WIDTH-1){1'b1}}, (r_a == r_b)};
      3'd7:    w_alu = {ALT, (r_a > r_b)};
      default: w_alu = r_work;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd    <= w_rd_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = r_rd;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;

    case (r_state)
      S_IDLE: w_accept = start;
      S_SHIFT: begin
        w_work_nxt = r_sel[0] ? {r_work[WIDTH-1], r_work[WIDTH-1:1]}
                              : {r_work[WIDTH-2:0], r_work[WIDTH-1]};
        w_cnt_nxt  = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        w_rd_nxt    = w_alu;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        // busy is already low here, so a new request is taken at the same edge
        w_accept    = start;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_accept) begin
      w_sel_nxt   = sel;
      w_a_nxt     = rs;
      w_b_nxt     = rt;
      w_work_nxt  = sel[0] ? rt : rs;
      w_cnt_nxt   = w_amt;
      w_state_nxt = (w_is_shift && (w_amt != '0)) ? S_SHIFT : S_FINISH;
    end

    w_busy_nxt = (w_state_nxt == S_SHIFT);
  end

  // Free-running refresh counter; digit index steps on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_digit   <= '0;
    end else begin
      r_refresh <= r_refresh + REFRESH_BITS'(1);
      if (&r_refresh) begin
        r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + DW'(1);
      end
    end
  end

  assign w_nibble = 4'(r_rd >> {r_digit, 2'b00});

  // Active-low hex glyphs, abcdefg order
  always_comb begin
    w_seg = 7'b1111111;
    case (w_nibble)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = 7'b1111111;
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign rd   = r_rd;
  assign seg  = w_seg;
  assign an   = ~(DIGITS'(1) << r_digit);

endmodule

// File: tb/tb_alu_seq_display.sv
// Directed bench for alu_seq_display (WIDTH=8, REFRESH_BITS=2) with a
// scoreboard of expected results and latencies.
module tb_alu_seq_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] sel;
  logic [7:0] rs, rt;
  logic       busy, done;
  logic [7:0] rd;
  logic [6:0] seg;
  logic [1:0] an;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] rd;
    int         lat;
  } exp_t;

  exp_t sb[$];

  alu_seq_display #(.WIDTH(8), .REFRESH_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .rd(rd), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request; returns in the cycle where done is high
  task automatic run_op(input string tag, input logic [2:0] s, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] e, input int lat,
                        input bit pester);
    exp_t x;
    int n, nb;
    logic [7:0] prev;
    x.rd = e;
    x.lat = lat;
    sb.push_back(x);
    prev = rd;
    sel = s; rs = a; rt = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; nb = 0;
    while (done !== 1'b1 && n < 50) begin
      if (busy === 1'b1) begin
        nb++;
        if (pester) begin
          start = 1'b1; sel = 3'd0; rs = 8'hFF; rt = 8'hFF;
        end
      end
      chk({tag, "_hold"}, rd, prev);
      tick();
      start = 1'b0;
      n++;
    end
    x = sb.pop_front();
    chk({tag, "_lat"}, n, x.lat);
    chk({tag, "_busy"}, nb, x.lat - 1);
    chk({tag, "_rd"}, rd, x.rd);
  endtask

  task automatic chk_digit(input string tag, input logic [1:0] an_want, input logic [6:0] seg_want);
    int n = 0;
    while (an !== an_want && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_an"}, an, an_want);
    chk({tag, "_seg"}, seg, seg_want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = '0; rs = '0; rt = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state and display rotation
    chk("rst_rd", rd, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_an", an, 2'b10);
    chk("rst_seg", seg, 7'b0000001);
    tick(); tick(); tick();
    chk("an_3cyc", an, 2'b10);
    tick();
    chk("an_4cyc", an, 2'b01);
    chk("seg_dig1", seg, 7'b0000001);
    tick(); tick(); tick(); tick();
    chk("an_8cyc", an, 2'b10);

    // Single-cycle ops
    run_op("add", 3'd0, 8'hF0, 8'h25, 8'h15, 1, 1'b0);
    tick();
    chk("add_done_pulse", done, 1'b0);
    chk_digit("disp15_d0", 2'b10, 7'b0100100);
    chk_digit("disp15_d1", 2'b01, 7'b1001111);
    run_op("sub", 3'd1, 8'h03, 8'h05, 8'hFE, 1, 1'b0);
    tick();
    run_op("and", 3'd2, 8'hF0, 8'h3C, 8'h30, 1, 1'b0);
    tick();
    run_op("or", 3'd3, 8'hF0, 8'h0F, 8'hFF, 1, 1'b0);
    tick();

    // Rotate with ignored start pulses while busy
    run_op("rotl3", 3'd4, 8'h81, 8'h03, 8'h0C, 4, 1'b1);
    tick();
    chk("rotl3_noqueue_done", done, 1'b0);
    chk("rotl3_noqueue_busy", busy, 1'b0);
    chk("rotl3_noqueue_rd", rd, 8'h0C);
    run_op("rotl7", 3'd4, 8'h01, 8'h07, 8'h80, 8, 1'b0);
    tick();
    run_op("rotl_hibits", 3'd4, 8'h01, 8'hF9, 8'h02, 2, 1'b0);
    tick();

    // Arithmetic right shifts
    run_op("asr2", 3'd5, 8'h02, 8'h90, 8'hE4, 3, 1'b0);
    tick();
    chk_digit("dispE4_d0", 2'b10, 7'b1001100);
    chk_digit("dispE4_d1", 2'b01, 7'b0110000);
    run_op("asr3_pos", 3'd5, 8'h03, 8'h40, 8'h08, 4, 1'b0);
    tick();
    run_op("asr0", 3'd5, 8'h00, 8'h9C, 8'h9C, 1, 1'b0);
    tick();
    run_op("rotl0", 3'd4, 8'h5B, 8'h08, 8'h5B, 1, 1'b0);

    // Back-to-back: each new request issued in the done cycle
    run_op("eq", 3'd6, 8'h5A, 8'h5A, 8'hFF, 1, 1'b0);
    run_op("gt", 3'd7, 8'h10, 8'h0F, 8'hAB, 1, 1'b0);
    run_op("gt_eq", 3'd7, 8'h33, 8'h33, 8'hAA, 1, 1'b0);
    run_op("neq", 3'd6, 8'h01, 8'h02, 8'hFE, 1, 1'b0);
    tick();

    // Reset during a shift aborts without a done pulse
    sel = 3'd4; rs = 8'h81; rt = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd", rd, 8'h00);
    chk("abort_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", done, 1'b0);
      tick();
    end
    run_op("after_abort", 3'd0, 8'h01, 8'h02, 8'h03, 1, 1'b0);
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
